// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-pass left-shift sequencer.
// The result bus is packed as {N, Z, C, V, data}.
package shift_pkg;

  localparam int WIDTH_D = 32;
  localparam int STEP_D  = 5;
  localparam int AMT_W_D = 5;

  localparam int FLAG_W = 4;
  localparam int FLAG_N = 35;
  localparam int FLAG_Z = 34;
  localparam int FLAG_C = 33;
  localparam int FLAG_V = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result bus between operand decode, the shift sequencer and writeback.
interface shift_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int AMT_W = 5
);
  import shift_pkg::*;

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // The producer holds its payload while valid is high and unaccepted;
  // ready never depends combinationally on valid.
  logic                      start_valid;
  logic                      start_ready;
  logic [WIDTH-1:0]          din;
  logic [AMT_W-1:0]          s_amt;
  logic                      res_valid;
  logic                      res_ready;
  logic [WIDTH+FLAG_W-1:0]   result;

  modport master (
    output start_valid, din, s_amt, res_ready,
    input  start_ready, res_valid, result
  );

  modport slave (
    input  start_valid, din, s_amt, res_ready,
    output start_ready, res_valid, result
  );

endinterface

// File: rtl/shift_step.sv
// One pass of the shifter: a << step with the last bit shifted out as carry.
// step is bounded by the per-pass limit; step == 0 yields carry 0.
module shift_step #(
  parameter int WIDTH = 32,
  parameter int SW    = 3
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    step,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] wide;

  // The extra top bit catches a[WIDTH-step], the last bit pushed out.
  assign wide  = {1'b0, a} << step;
  assign y     = wide[WIDTH-1:0];
  assign carry = wide[WIDTH];

endmodule

// File: rtl/shift_sequencer.sv
// Breaks a 0..31 left shift into passes of at most STEP bits, then
// presents the shifted data with N/Z/C/V flags on the result bus.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_D,
  parameter int STEP  = STEP_D,
  parameter int AMT_W = AMT_W_D
) (
  input  logic              clk,
  input  logic              reset_n,
  shift_sequencer_if.slave  bus,
  input  logic              abort,
  output logic              busy,
  output logic [2:0]        pass_cnt,
  output state_t            dbg_state
);

  localparam int SW = $clog2(STEP + 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_sh;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_nx;
  logic             carry;
  logic             carry_sh;
  logic [SW-1:0]    step;

  // Per-pass amount is the remaining shift clipped to the shifter limit.
  always_comb begin
    step = SW'(STEP);
    if (rem < AMT_W'(STEP)) step = rem[SW-1:0];
  end

  assign rem_nx = rem - AMT_W'(step);

  shift_step #(.WIDTH(WIDTH), .SW(SW)) u_step (
    .a     (acc),
    .step  (step),
    .y     (acc_sh),
    .carry (carry_sh)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // abort wins over both pass completion and the result handshake.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start_valid) state_nx = (bus.s_amt != '0) ? SHIFT : DONE;
      SHIFT:   if (abort) state_nx = IDLE;
               else if (rem_nx == '0) state_nx = DONE;
      DONE:    if (abort || bus.res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      rem      <= '0;
      carry    <= 1'b0;
      pass_cnt <= '0;
    end else if (state == IDLE && bus.start_valid) begin
      acc      <= bus.din;
      rem      <= bus.s_amt;
      carry    <= 1'b0;
      pass_cnt <= '0;
    end else if (state == SHIFT && !abort) begin
      acc      <= acc_sh;
      carry    <= carry_sh;
      rem      <= rem_nx;
      pass_cnt <= pass_cnt + 3'd1;
    end
  end

  // Outputs decode the state register only; result is zero outside DONE.
  always_comb begin
    bus.start_ready = (state == IDLE);
    busy            = (state != IDLE);
    bus.res_valid   = (state == DONE);
    bus.result      = '0;
    if (state == DONE) bus.result = {acc[WIDTH-1], (acc == '0), carry, 1'b0, acc};
    dbg_state       = state;
  end

endmodule
